// File: rtl/muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// muldiv_unit : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Rev 1.0
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int                CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]     CNT_INIT = CW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    // Operand magnitudes; op[0]=0 selects the signed variants
    logic                 a_neg, b_neg;
    logic [WIDTH-1:0]     a_mag, b_mag;
    assign a_neg = ~op[0] & a[WIDTH-1];
    assign b_neg = ~op[0] & b[WIDTH-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Shift-add: product grows into the top half while the multiplier drains out the bottom
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring divide: partial remainder on top, quotient bits shift in at the bottom
    logic [WIDTH:0]       div_top;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [2*WIDTH-1:0]   div_next;
    assign div_top  = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_ge   = (div_top >= {1'b0, opnd_q});
    assign div_diff = div_top[WIDTH-1:0] - opnd_q;
    assign div_next = {(div_ge ? div_diff : div_top[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
    assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
    assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opnd_d    = b_mag;
                    is_div_d  = op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = CNT_INIT;
                    busy_d    = 1'b1;
                    state_d   = S_RUN;
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            S_RUN: begin
                acc_d = is_div_q ? div_next : mul_next;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
                if (is_div_q) begin
                    // A zero divisor leaves |a| in the remainder, so re-signing it restores raw a
                    hi_d = rem_fix;
                    lo_d = (opnd_q == '0) ? '1 : quo_fix;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_muldiv_unit : directed plus randomized checks of muldiv_unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int               vectors;
    int               miscompares;
    logic [31:0]      exp_hi;
    logic [31:0]      exp_lo;

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .mthi    (mthi),
        .mtlo    (mtlo),
        .wdata   (wdata),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {hi, lo} straight from the arithmetic definition of each instruction
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x,
                                              input logic [31:0] y);
        longint          sp, sq, sr;
        longint unsigned up;
        logic [63:0]     res;
        res = '0;
        case (o)
            2'b00: begin
                sp  = longint'($signed(x)) * longint'($signed(y));
                res = sp;
            end
            2'b01: begin
                up  = {32'b0, x} * {32'b0, y};
                res = up;
            end
            2'b10: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else begin
                    sq  = longint'($signed(x)) / longint'($signed(y));
                    sr  = longint'($signed(x)) % longint'($signed(y));
                    res = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == 32'd0) res = {x, 32'hFFFF_FFFF};
                else            res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    // Launch one op at the next edge and follow it to completion.
    // disturb: retry start plus mthi at E5 while busy; mv: assert mtlo with the start.
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input bit mv, input bit disturb);
        logic [31:0] oh, ol;
        logic [63:0] r;
        int          n;
        bit          held;
        r     = ref_model(o, x, y);
        oh    = hi;
        ol    = lo;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        mtlo  = mv;
        mthi  = 1'b0;
        wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        mtlo  = 1'b0;
        chk("busy_rise", {63'b0, busy}, 64'd1);
        n    = 0;
        held = 1'b1;
        while (!done && n < 100) begin
            if (disturb && n == 4) begin
                start = 1'b1; mthi = 1'b1; wdata = 32'h5555_AAAA; a = ~x; op = ~o;
            end
            if (disturb && n == 5) begin
                start = 1'b0; mthi = 1'b0; a = x; op = o;
            end
            @(posedge clk); #1;
            n++;
            if (!done && (hi !== oh || lo !== ol || busy !== 1'b1)) held = 1'b0;
        end
        chk("latency", 64'(n), 64'(WIDTH + 1));
        chk("hold_during_run", {63'b0, held}, 64'd1);
        chk("busy_fall", {63'b0, busy}, 64'd0);
        chk("hi", {32'b0, hi}, {32'b0, r[63:32]});
        chk("lo", {32'b0, lo}, {32'b0, r[31:0]});
        exp_hi = r[63:32];
        exp_lo = r[31:0];
    endtask

    task automatic do_move(input bit h, input bit l, input logic [31:0] d);
        mthi  = h;
        mtlo  = l;
        wdata = d;
        @(posedge clk); #1;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (h) exp_hi = d;
        if (l) exp_lo = d;
        chk("move_hi", {32'b0, hi}, {32'b0, exp_hi});
        chk("move_lo", {32'b0, lo}, {32'b0, exp_lo});
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        op          = 2'b00;
        a           = '0;
        b           = '0;
        mthi        = 1'b0;
        mtlo        = 1'b0;
        wdata       = '0;
        exp_hi      = '0;
        exp_lo      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {63'b0, busy}, 64'd0);
        chk("rst_done", {63'b0, done}, 64'd0);
        chk("rst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("multu_max_hi", {32'b0, hi}, 64'hFFFF_FFFE);
        chk("multu_max_lo", {32'b0, lo}, 64'h0000_0001);
        chk("done_pulse", {63'b0, done}, 64'd1);
        @(posedge clk); #1;
        chk("done_drop", {63'b0, done}, 64'd0);

        do_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, 1'b0);
        chk("mult_neg_lo", {32'b0, lo}, 64'hFFFF_FFEB);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg_lo", {32'b0, lo}, 64'hFFFF_FFFD);
        do_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
        do_op(2'b11, 32'd5, 32'd0, 1'b0, 1'b0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_lo", {32'b0, lo}, 64'h8000_0000);
        do_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0);

        // Busy-time start/mthi ignored, then a back-to-back launch while done is high
        do_op(2'b01, 32'h0001_0003, 32'h0002_0005, 1'b0, 1'b1);
        chk("b2b_done_high", {63'b0, done}, 64'd1);
        do_op(2'b11, 32'hFFFF_FFFF, 32'd10, 1'b0, 1'b0);

        @(negedge clk);
        do_move(1'b1, 1'b1, 32'h0000_1234);
        do_op(2'b01, 32'd6, 32'd7, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a divide
        @(negedge clk);
        op = 2'b10; a = 32'h7654_3210; b = 32'd9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_done", {63'b0, done}, 64'd0);
        chk("arst_hilo", {hi, lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_op(2'b01, 32'd3, 32'd4, 1'b0, 1'b0);
        chk("post_rst_lo", {32'b0, lo}, 64'd12);

        for (int i = 0; i < 150; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: begin ra = $urandom_range(0, 255); rb = $urandom_range(1, 15); end
                3: rb = -($urandom_range(1, 20));
                default: ;
            endcase
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                do_move(1'($urandom), 1'($urandom), $urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk); #1;
                chk("rand_done_drop", {63'b0, done}, 64'd0);
            end
            do_op(ro, ra, rb, ($urandom_range(0, 7) == 0), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
